// File: rtl/reg_timeout_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_timeout_guard_pkg
// Description : Register-bus request/response types used by the timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_timeout_guard_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/reg_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : reg_timeout_guard
// Description : Zero-latency register-bus pass-through that error-terminates
//               stalled requests and isolates the slave until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_timeout_guard
  import reg_timeout_guard_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 32,
  parameter logic [31:0] ErrData       = 32'hBADC_AB1E,
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  req_t       reg_req_i,
  output rsp_t       reg_rsp_o,
  output req_t       reg_req_o,
  input  rsp_t       reg_rsp_i,
  input  logic       clear_i,
  output logic       timeout_o,
  output logic       isolated_o,
  output logic [7:0] timeout_cnt_o
);

  localparam int unsigned     CntW      = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam bit              c_enabled = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] c_limit   = c_enabled ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ISOLATE = 2'd2
  } state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_wait_cnt;
  logic [7:0]      r_timeout_cnt;
  logic            w_stalled;

  assign w_stalled = reg_req_i.valid && !reg_rsp_i.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_ACTIVE;
      r_wait_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (c_enabled && r_state == ST_ACTIVE && w_stalled) begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_state == ST_TIMEOUT && r_timeout_cnt != 8'hFF) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    reg_req_o    = reg_req_i;
    reg_rsp_o    = reg_rsp_i;
    timeout_o    = 1'b0;
    isolated_o   = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (c_enabled && w_stalled && r_wait_cnt == c_limit) begin
          w_state_next = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        reg_req_o.valid = 1'b0;
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = ErrData;
        reg_rsp_o.error = 1'b1;
        reg_rsp_o.ready = 1'b1;
        timeout_o       = 1'b1;
        w_state_next    = ST_ISOLATE;
      end
      ST_ISOLATE: begin
        // The slave is cut off; upstream requests are answered locally.
        reg_req_o.valid = 1'b0;
        reg_rsp_o       = '0;
        isolated_o      = 1'b1;
        if (reg_req_i.valid) begin
          reg_rsp_o.rdata = ErrData;
          reg_rsp_o.error = 1'b1;
          reg_rsp_o.ready = 1'b1;
        end
        if (clear_i) begin
          w_state_next = ST_ACTIVE;
        end
      end
      default: begin
        w_state_next = ST_ACTIVE;
      end
    endcase
  end

  assign timeout_cnt_o = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_timeout_guard
// Description : Self-checking bench for reg_timeout_guard (limit 32 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_timeout_guard;
  import reg_timeout_guard_pkg::*;

  localparam int unsigned T   = 32;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic     clk     = 1'b0;
  logic     rst_n   = 1'b0;
  logic     clear   = 1'b0;
  reg_req_t req_in  = '0;
  reg_rsp_t rsp_in  = '0;

  reg_req_t   req_out, req_out0;
  reg_rsp_t   rsp_out, rsp_out0;
  logic       to_o, to_o0, iso_o, iso_o0;
  logic [7:0] tcnt_o, tcnt_o0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_timeout_guard #(.TimeoutCycles(T), .ErrData(ERR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req_in), .reg_rsp_o(rsp_out),
    .reg_req_o(req_out), .reg_rsp_i(rsp_in), .clear_i(clear),
    .timeout_o(to_o), .isolated_o(iso_o), .timeout_cnt_o(tcnt_o)
  );

  reg_timeout_guard #(.TimeoutCycles(0), .ErrData(ERR)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req_in), .reg_rsp_o(rsp_out0),
    .reg_req_o(req_out0), .reg_rsp_i(rsp_in), .clear_i(clear),
    .timeout_o(to_o0), .isolated_o(iso_o0), .timeout_cnt_o(tcnt_o0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: how long the current request has stalled, whether this
  // cycle is the error-termination cycle, whether the slave is cut off.
  int m_wait = 0;
  bit m_to   = 1'b0;
  bit m_iso  = 1'b0;
  int m_tcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0; m_to <= 1'b0; m_iso <= 1'b0; m_tcnt <= 0;
    end else if (m_to) begin
      m_to <= 1'b0; m_iso <= 1'b1; m_wait <= 0;
      m_tcnt <= (m_tcnt < 255) ? m_tcnt + 1 : 255;
    end else if (m_iso) begin
      if (clear) m_iso <= 1'b0;
    end else if (req_in.valid && !rsp_in.ready) begin
      if (m_wait == int'(T) - 1) m_to <= 1'b1;
      m_wait <= m_wait + 1;
    end else begin
      m_wait <= 0;
    end
  end

  always @(negedge clk) begin
    reg_req_t exp_req;
    reg_rsp_t err_rsp;
    exp_req = req_in;
    err_rsp = '{rdata: ERR, error: 1'b1, ready: 1'b1};
    if (m_to) begin
      exp_req.valid = 1'b0;
      chk("rsp_timeout", rsp_out, err_rsp);
    end else if (m_iso) begin
      exp_req.valid = 1'b0;
      if (req_in.valid) chk("rsp_isolate", rsp_out, err_rsp);
      else              chk("rsp_isolate_idle_ready", rsp_out.ready, 1'b0);
    end else begin
      chk("rsp_passthru", rsp_out, rsp_in);
    end
    chk("req_out", req_out, exp_req);
    chk("timeout_o", to_o, m_to);
    chk("isolated_o", iso_o, m_iso);
    chk("timeout_cnt_o", tcnt_o, m_tcnt[7:0]);
    chk("t0_req_out", req_out0, req_in);
    chk("t0_rsp_out", rsp_out0, rsp_in);
    chk("t0_flags", {to_o0, iso_o0, tcnt_o0}, 10'd0);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_in = '{addr: a, write: w, wdata: d, wstrb: 4'hF, valid: v};
  endtask

  task automatic set_rsp(input bit rdy, input logic [31:0] rd);
    rsp_in = '{rdata: rd, error: 1'b0, ready: rdy};
  endtask

  initial begin
    #1;
    chk("reset_flags", {to_o, iso_o, tcnt_o}, 10'd0);
    chk("reset_ready", rsp_out.ready, 1'b0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;

    // Read completes in cycle 3
    next_cycle(); set_req(1, 0, 32'h10, 0); set_rsp(0, 0);
    repeat (2) next_cycle();
    next_cycle(); set_rsp(1, 32'hCAFE); #1;
    chk("read_cafe_rsp", rsp_out, {32'hCAFE, 1'b0, 1'b1});
    next_cycle(); set_req(0, 0, 0, 0); set_rsp(0, 0);

    // Slave never ready: timeout in cycle 32
    next_cycle(); set_req(1, 0, 32'h14, 0); #1;
    chk("stall_c0_valid", req_out.valid, 1'b1);
    repeat (31) next_cycle(); #1;
    chk("stall_c31_valid", req_out.valid, 1'b1);
    chk("stall_c31_no_to", to_o, 1'b0);
    next_cycle(); #1;
    chk("to_c32_rsp", rsp_out, {32'hBADCAB1E, 1'b1, 1'b1});
    chk("to_c32_pulse", to_o, 1'b1);
    chk("to_c32_valid", req_out.valid, 1'b0);
    next_cycle(); set_req(0, 0, 0, 0); #1;
    chk("c33_isolated", iso_o, 1'b1);
    chk("c33_tcnt", tcnt_o, 8'd1);

    // Write while isolated, then clear coincident with a request
    next_cycle(); set_req(1, 1, 32'h20, 32'h1234); set_rsp(1, 0); #1;
    chk("iso_wr_rsp", {rsp_out.error, rsp_out.ready}, 2'b11);
    chk("iso_wr_valid", req_out.valid, 1'b0);
    chk("iso_wr_addr", req_out.addr, 32'h20);
    next_cycle(); clear = 1'b1; #1;
    chk("iso_clear_err", rsp_out.error, 1'b1);
    next_cycle(); clear = 1'b0; set_req(0, 0, 0, 0); #1;
    chk("cleared", iso_o, 1'b0);
    next_cycle(); set_req(1, 1, 32'h20, 32'h5678); #1;
    chk("post_clear_valid", req_out.valid, 1'b1);
    chk("post_clear_ok", rsp_out.error, 1'b0);
    next_cycle(); set_req(0, 0, 0, 0); set_rsp(0, 0);

    // Ready exactly in cycle 31 is a normal completion; clear in ACTIVE ignored
    next_cycle(); set_req(1, 0, 32'h30, 0);
    repeat (30) next_cycle();
    next_cycle(); set_rsp(1, 32'h55); #1;
    chk("c31_ready_rsp", rsp_out, {32'h55, 1'b0, 1'b1});
    chk("c31_no_to", to_o, 1'b0);
    next_cycle(); set_req(0, 0, 0, 0); set_rsp(0, 0); clear = 1'b1; #1;
    chk("c31_not_iso", iso_o, 1'b0);
    next_cycle(); clear = 1'b0;

    // Saturate the timeout counter
    for (int i = 0; i < 300; i++) begin
      next_cycle(); set_req(1, 0, 32'h40, 0);
      repeat (32) next_cycle();
      next_cycle(); set_req(0, 0, 0, 0);
      next_cycle(); clear = 1'b1;
      next_cycle(); clear = 1'b0;
    end
    #1;
    chk("tcnt_saturated", tcnt_o, 8'd255);

    // Reset in cycle 10 of a stalled request
    next_cycle(); set_req(1, 0, 32'h44, 0);
    repeat (10) next_cycle();
    rst_n = 1'b0; #1;
    chk("midrst_flags", {to_o, iso_o, tcnt_o}, 10'd0);
    chk("midrst_ready", rsp_out.ready, 1'b0);
    set_req(0, 0, 0, 0);
    next_cycle(); next_cycle(); rst_n = 1'b1;
    next_cycle(); set_req(1, 0, 32'h48, 0); #1;
    chk("postrst_valid", req_out.valid, 1'b1);
    repeat (30) next_cycle();
    next_cycle(); set_rsp(1, 32'h77); #1;
    chk("postrst_c31_ok", {rsp_out.error, rsp_out.ready, to_o}, 3'b010);
    next_cycle(); set_req(0, 0, 0, 0); set_rsp(0, 0); #1;
    chk("postrst_not_iso", iso_o, 1'b0);
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
